// File: rtl/handshake_constant_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | handshake_constant_check                                                   |
// | Constant-token sink: buffers up to DEPTH dataless tokens, flags first      |
// | accepted word differing from EXPECTED, counts accepted tokens.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module handshake_constant_check #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED   = 'hF0B,
  parameter int                    DEPTH      = 2,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  mismatch,
  output logic [DATA_WIDTH-1:0] mismatch_data,
  output logic [CNT_WIDTH-1:0]  token_count
);

  localparam int                 c_OCC_W   = $clog2(DEPTH + 1);
  localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(DEPTH);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  logic [c_OCC_W-1:0]    r_occ;
  logic                  r_mismatch;
  logic [DATA_WIDTH-1:0] r_mismatch_data;
  logic [CNT_WIDTH-1:0]  r_token_count;

  logic w_acc;
  logic w_rel;

  // Handshake outputs depend only on registered occupancy (and reset).
  assign ins_ready  = ~rst & (r_occ != c_FULL);
  assign outs_valid = (r_occ != '0);

  assign w_acc = ins_valid & ins_ready;
  assign w_rel = outs_valid & outs_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ           <= '0;
      r_mismatch      <= 1'b0;
      r_mismatch_data <= '0;
      r_token_count   <= '0;
    end else begin
      if (w_acc && !w_rel) begin
        r_occ <= r_occ + c_OCC_ONE;
      end else if (w_rel && !w_acc) begin
        r_occ <= r_occ - c_OCC_ONE;
      end

      if (w_acc) begin
        r_token_count <= r_token_count + c_CNT_ONE;
        // Only the first offending word is captured; flow is never stalled.
        if ((ins != EXPECTED) && !r_mismatch) begin
          r_mismatch      <= 1'b1;
          r_mismatch_data <= ins;
        end
      end
    end
  end

  assign mismatch      = r_mismatch;
  assign mismatch_data = r_mismatch_data;
  assign token_count   = r_token_count;

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_check.sv
`default_nettype none
// Bench for handshake_constant_check: directed scenarios plus random traffic,
// checked against a token-level reference model through a scoreboard queue.
module tb_handshake_constant_check;

  localparam int          DEPTH = 2;
  localparam logic [31:0] EXPV  = 32'hF0B;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        outs_valid;
  logic        outs_ready;
  logic        mismatch;
  logic [31:0] mismatch_data;
  logic [3:0]  token_count;

  handshake_constant_check #(
    .DATA_WIDTH(32),
    .EXPECTED  (32'hF0B),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .outs_valid   (outs_valid),
    .outs_ready   (outs_ready),
    .mismatch     (mismatch),
    .mismatch_data(mismatch_data),
    .token_count  (token_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic        mm;
    logic [31:0] md;
    logic [3:0]  tc;
  } exp_t;

  exp_t exp_q[$];
  int   tok_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: tokens held, sticky flag, first bad word, count.
  int          m_occ = 0;
  logic        m_mm  = 1'b0;
  logic [31:0] m_md  = 32'h0;
  int          m_tc  = 0;
  int          m_id  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic o);
    @(negedge clk);
    rst        = r;
    ins_valid  = v;
    ins        = d;
    outs_ready = o;
  endtask

  // Model: predicts this cycle's outputs, then advances to the next cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      begin
        exp_t e;
        logic acc;
        logic rel;
        e.ir = !rst && (m_occ != DEPTH);
        e.ov = (m_occ != 0);
        e.mm = m_mm;
        e.md = m_md;
        e.tc = 4'(m_tc);
        exp_q.push_back(e);
        if (rst) begin
          m_occ = 0;
          m_mm  = 1'b0;
          m_md  = 32'h0;
          m_tc  = 0;
          tok_q.delete();
        end else begin
          acc = ins_valid && e.ir;
          rel = e.ov && outs_ready;
          if (acc) begin
            m_tc = (m_tc + 1) % 16;
            if (ins != EXPV && !m_mm) begin
              m_mm = 1'b1;
              m_md = ins;
            end
            tok_q.push_back(m_id);
            m_id++;
          end
          m_occ = m_occ + (acc ? 1 : 0) - (rel ? 1 : 0);
        end
      end
    end
  end

  // Monitor: compares DUT outputs and consumes ctrl tokens it releases.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        check("exp_queue_empty", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ins_ready",     32'(ins_ready),     32'(e.ir));
        check("outs_valid",    32'(outs_valid),    32'(e.ov));
        check("mismatch",      32'(mismatch),      32'(e.mm));
        check("mismatch_data", mismatch_data,      e.md);
        check("token_count",   32'(token_count),   32'(e.tc));
      end
      if (!rst && outs_valid === 1'b1 && outs_ready) begin
        check("ctrl_token_available", 32'(tok_q.size() != 0), 32'd1);
        if (tok_q.size() != 0) void'(tok_q.pop_front());
      end
    end
  end

  initial begin
    rst        = 1'b1;
    ins_valid  = 1'b0;
    ins        = 32'h0;
    outs_ready = 1'b0;
    repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Single token, then idle.
    drive(1'b0, 1'b1, EXPV, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Fill while blocked, then drain.
    repeat (4) drive(1'b0, 1'b1, EXPV, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Full buffer with both sides active.
    repeat (3) drive(1'b0, 1'b1, EXPV, 1'b0);
    repeat (10) drive(1'b0, 1'b1, EXPV, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // First mismatch captured and held.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, EXPV, 1'b1);
    drive(1'b0, 1'b1, 32'h123, 1'b1);
    drive(1'b0, 1'b1, 32'h456, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Counter wrap: 17 accepts.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (17) drive(1'b0, 1'b1, EXPV, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while full and flagged, with both handshakes requested.
    drive(1'b0, 1'b1, 32'h777, 1'b0);
    drive(1'b0, 1'b1, EXPV, 1'b0);
    drive(1'b0, 1'b1, EXPV, 1'b0);
    drive(1'b1, 1'b1, EXPV, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Random traffic with occasional resets and bad words.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7,
            ($urandom_range(0, 9) == 0) ? 32'($urandom) : EXPV,
            $urandom_range(0, 9) < 6);
    end

    repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #3;
    check("tokens_in_eq_out", 32'(tok_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
